// File: rtl/result_stage_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spu_pipe_pkg
// Description : Shared widths and types for the result staging pipeline.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package spu_pipe_pkg;

    localparam int C_LANES     = 2;
    localparam int C_DEPTH     = 8;
    localparam int C_DATA_W    = 128;
    localparam int C_ADDR_W    = 7;
    localparam int C_LAT_W     = 4;
    localparam int C_FWD_PORTS = 6;

    typedef logic [$clog2(C_LANES)-1:0] lane_idx_t;

    typedef struct packed {
        logic                valid;
        logic                wr_en;
        logic [C_ADDR_W-1:0] rt_addr;
        logic [C_LAT_W-1:0]  lat;
        logic [C_DATA_W-1:0] data;
    } stg_entry_t;

endpackage
`default_nettype wire

// File: rtl/result_stage_pipe_fwd_lookup.sv
`default_nettype none
// ============================================================================
// Module      : fwd_lookup
// Description : Priority match of one query address against all staged
//               entries; candidate 0 is the youngest and has top priority.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module fwd_lookup #(
    parameter int N      = 16,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 128
) (
    input  logic [ADDR_W-1:0]           i_query,
    input  logic [N-1:0]                i_cand_en,
    input  logic [N-1:0]                i_cand_rdy,
    input  logic [N-1:0][ADDR_W-1:0]    i_cand_addr,
    input  logic [N-1:0][DATA_W-1:0]    i_cand_data,
    output logic                        o_hit,
    output logic                        o_ready,
    output logic [DATA_W-1:0]           o_data
);

    // Oldest first so the last (youngest) match overrides.
    always_comb begin
        o_hit   = 1'b0;
        o_ready = 1'b0;
        o_data  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_cand_en[k] && (i_cand_addr[k] == i_query)) begin
                o_hit   = 1'b1;
                o_ready = i_cand_rdy[k];
                o_data  = i_cand_data[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : result_stage_pipe
// Description : Multi-lane result staging pipe with forwarding, branch flush
//               and register-file writeback.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module result_stage_pipe
    import spu_pipe_pkg::*;
#(
    parameter int LANES     = C_LANES,
    parameter int DEPTH     = C_DEPTH,
    parameter int DATA_W    = C_DATA_W,
    parameter int ADDR_W    = C_ADDR_W,
    parameter int LAT_W     = C_LAT_W,
    parameter int FWD_PORTS = C_FWD_PORTS,
    parameter int CNT_W     = $clog2(LANES * DEPTH + 1),
    localparam int STG_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [LANES-1:0]                 iss_valid,
    input  logic [LANES-1:0]                 iss_wr_en,
    input  logic [LANES-1:0][ADDR_W-1:0]     iss_rt_addr,
    input  logic [LANES-1:0][LAT_W-1:0]      iss_lat,
    input  logic [LANES-1:0][DATA_W-1:0]     iss_data,
    input  logic                             flush,
    input  logic [STG_W-1:0]                 flush_stage,
    input  logic [LANE_W-1:0]                flush_lane,
    input  logic [FWD_PORTS-1:0][ADDR_W-1:0] fq_addr,
    output logic [FWD_PORTS-1:0]             fq_hit,
    output logic [FWD_PORTS-1:0]             fq_ready,
    output logic [FWD_PORTS-1:0][DATA_W-1:0] fq_data,
    output logic                             fq_stall,
    output logic [LANES-1:0]                 wb_valid,
    output logic [LANES-1:0][ADDR_W-1:0]     wb_addr,
    output logic [LANES-1:0][DATA_W-1:0]     wb_data,
    output logic [CNT_W-1:0]                 inflight,
    output logic                             lat_err
);

    localparam int               C_N_ENT   = LANES * DEPTH;
    localparam logic [LAT_W-1:0] C_LAT_MAX = LAT_W'(DEPTH);
    localparam logic [LAT_W-1:0] C_LAT_MIN = LAT_W'(1);

    logic [DEPTH-1:0][LANES-1:0]             r_valid;
    logic [DEPTH-1:0][LANES-1:0]             r_wr_en;
    logic [DEPTH-1:0][LANES-1:0][ADDR_W-1:0] r_addr;
    logic [DEPTH-1:0][LANES-1:0][LAT_W-1:0]  r_lat;
    logic [DEPTH-1:0][LANES-1:0][DATA_W-1:0] r_data;
    logic [CNT_W-1:0]                        r_inflight;
    logic                                    r_lat_err;

    logic [DEPTH-1:0][LANES-1:0]             w_kill;
    logic [DEPTH-1:0][LANES-1:0]             w_valid_nxt;
    logic [LANES-1:0][LAT_W-1:0]             w_lat_iss;
    logic                                    w_lat_bad;
    logic [CNT_W-1:0]                        w_cnt_nxt;
    logic [LANES-1:0]                        w_wb_en;
    logic [C_N_ENT-1:0]                      w_cand_en;
    logic [C_N_ENT-1:0]                      w_cand_rdy;
    logic [C_N_ENT-1:0][ADDR_W-1:0]          w_cand_addr;
    logic [C_N_ENT-1:0][DATA_W-1:0]          w_cand_data;

    // Everything younger than the branch: earlier stages, or same stage and higher lane.
    always_comb begin
        w_kill = '0;
        for (int s = 0; s < DEPTH; s++) begin
            for (int l = 0; l < LANES; l++) begin
                w_kill[s][l] = flush && ((s < int'(flush_stage)) ||
                               ((s == int'(flush_stage)) && (l > int'(flush_lane))));
            end
        end
    end

    always_comb begin
        w_lat_bad = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            w_lat_iss[l] = iss_lat[l];
            if (iss_lat[l] == '0) begin
                w_lat_iss[l] = C_LAT_MIN;
            end else if (iss_lat[l] > C_LAT_MAX) begin
                w_lat_iss[l] = C_LAT_MAX;
            end
            w_lat_bad = w_lat_bad | (iss_valid[l] && (iss_lat[l] > C_LAT_MAX));
        end
    end

    always_comb begin
        w_valid_nxt    = '0;
        w_valid_nxt[0] = flush ? '0 : iss_valid;
        for (int s = 1; s < DEPTH; s++) begin
            w_valid_nxt[s] = r_valid[s-1] & ~w_kill[s-1];
        end
        w_cnt_nxt = '0;
        for (int s = 0; s < DEPTH; s++) begin
            for (int l = 0; l < LANES; l++) begin
                w_cnt_nxt = w_cnt_nxt + CNT_W'(w_valid_nxt[s][l]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_wr_en    <= '0;
            r_addr     <= '0;
            r_lat      <= '0;
            r_data     <= '0;
            r_inflight <= '0;
            r_lat_err  <= 1'b0;
        end else begin
            r_valid    <= w_valid_nxt;
            r_wr_en[0] <= iss_wr_en;
            r_addr[0]  <= iss_rt_addr;
            r_lat[0]   <= w_lat_iss;
            r_data[0]  <= iss_data;
            for (int s = 1; s < DEPTH; s++) begin
                r_wr_en[s] <= r_wr_en[s-1];
                r_addr[s]  <= r_addr[s-1];
                r_lat[s]   <= r_lat[s-1];
                r_data[s]  <= r_data[s-1];
            end
            r_inflight <= w_cnt_nxt;
            r_lat_err  <= r_lat_err | w_lat_bad;
        end
    end

    // Candidate order: stage ascending, lane descending within a stage.
    always_comb begin
        for (int s = 0; s < DEPTH; s++) begin
            for (int l = 0; l < LANES; l++) begin
                w_cand_en  [s*LANES + (LANES-1-l)] = r_valid[s][l] & r_wr_en[s][l];
                w_cand_rdy [s*LANES + (LANES-1-l)] = ((s + 1) >= int'(r_lat[s][l]));
                w_cand_addr[s*LANES + (LANES-1-l)] = r_addr[s][l];
                w_cand_data[s*LANES + (LANES-1-l)] = r_data[s][l];
            end
        end
    end

    generate
        for (genvar p = 0; p < FWD_PORTS; p++) begin : g_fwd
            fwd_lookup #(
                .N      (C_N_ENT),
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_fwd_lookup (
                .i_query     (fq_addr[p]),
                .i_cand_en   (w_cand_en),
                .i_cand_rdy  (w_cand_rdy),
                .i_cand_addr (w_cand_addr),
                .i_cand_data (w_cand_data),
                .o_hit       (fq_hit[p]),
                .o_ready     (fq_ready[p]),
                .o_data      (fq_data[p])
            );
        end
    endgenerate

    assign fq_stall = |(fq_hit & ~fq_ready);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_wb_en[l] = r_valid[DEPTH-1][l] & r_wr_en[DEPTH-1][l] & ~w_kill[DEPTH-1][l];
        end
    end

    // A younger lane writing the same register supersedes older lanes.
    always_comb begin
        wb_valid = w_wb_en;
        for (int l = 0; l < LANES; l++) begin
            for (int m = l + 1; m < LANES; m++) begin
                if (w_wb_en[m] && (r_addr[DEPTH-1][m] == r_addr[DEPTH-1][l])) begin
                    wb_valid[l] = 1'b0;
                end
            end
        end
    end

    assign wb_addr  = r_addr[DEPTH-1];
    assign wb_data  = r_data[DEPTH-1];
    assign inflight = r_inflight;
    assign lat_err  = r_lat_err;

endmodule
`default_nettype wire

// File: tb/tb_result_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_stage_pipe
// Description : Scoreboard bench for result_stage_pipe with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_stage_pipe;

    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int DW    = 128;
    localparam int AW    = 7;
    localparam int LW    = 4;
    localparam int FP    = 6;
    localparam int CW    = $clog2(LANES * DEPTH + 1);

    localparam int K_INF   = 0;
    localparam int K_LERR  = 1;
    localparam int K_HIT   = 2;
    localparam int K_RDY   = 3;
    localparam int K_DATA  = 4;
    localparam int K_STALL = 5;

    logic                      clk;
    logic                      rst_n;
    logic [LANES-1:0]          iss_valid;
    logic [LANES-1:0]          iss_wr_en;
    logic [LANES-1:0][AW-1:0]  iss_rt_addr;
    logic [LANES-1:0][LW-1:0]  iss_lat;
    logic [LANES-1:0][DW-1:0]  iss_data;
    logic                      flush;
    logic [2:0]                flush_stage;
    logic [0:0]                flush_lane;
    logic [FP-1:0][AW-1:0]     fq_addr;
    logic [FP-1:0]             fq_hit;
    logic [FP-1:0]             fq_ready;
    logic [FP-1:0][DW-1:0]     fq_data;
    logic                      fq_stall;
    logic [LANES-1:0]          wb_valid;
    logic [LANES-1:0][AW-1:0]  wb_addr;
    logic [LANES-1:0][DW-1:0]  wb_data;
    logic [CW-1:0]             inflight;
    logic                      lat_err;

    result_stage_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (iss_valid),
        .iss_wr_en   (iss_wr_en),
        .iss_rt_addr (iss_rt_addr),
        .iss_lat     (iss_lat),
        .iss_data    (iss_data),
        .flush       (flush),
        .flush_stage (flush_stage),
        .flush_lane  (flush_lane),
        .fq_addr     (fq_addr),
        .fq_hit      (fq_hit),
        .fq_ready    (fq_ready),
        .fq_data     (fq_data),
        .fq_stall    (fq_stall),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .inflight    (inflight),
        .lat_err     (lat_err)
    );

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        int          idx;
        logic [DW-1:0] exp;
    } chk_t;

    typedef struct {
        int          lane;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    chk_t chk_q[$];
    wb_t  wb_q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_at(input int dc, input string nm, input int kind, input int idx,
                          input logic [DW-1:0] v);
        chk_t c;
        c.cyc  = cyc + dc;
        c.name = nm;
        c.kind = kind;
        c.idx  = idx;
        c.exp  = v;
        chk_q.push_back(c);
    endtask

    task automatic set_iss(input int l, input logic wr, input logic [AW-1:0] rt,
                           input logic [LW-1:0] lat, input logic [DW-1:0] d, input bit push_wb);
        wb_t w;
        iss_valid[l]   = 1'b1;
        iss_wr_en[l]   = wr;
        iss_rt_addr[l] = rt;
        iss_lat[l]     = lat;
        iss_data[l]    = d;
        if (push_wb && wr) begin
            w.lane = l;
            w.addr = rt;
            w.data = d;
            wb_q.push_back(w);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        iss_valid = '0;
        flush     = 1'b0;
    endtask

    task automatic drain();
        repeat (DEPTH + 1) step();
        fq_addr = {FP{7'h7F}};
    endtask

    // Monitor: timed checks plus writeback scoreboard.
    always @(negedge clk) begin
        chk_t c;
        wb_t  w;
        logic [DW-1:0] act;
        int i;
        i = 0;
        while (i < chk_q.size()) begin
            if (chk_q[i].cyc == cyc) begin
                c = chk_q[i];
                case (c.kind)
                    K_INF:   act = DW'(inflight);
                    K_LERR:  act = DW'(lat_err);
                    K_HIT:   act = DW'(fq_hit[c.idx]);
                    K_RDY:   act = DW'(fq_ready[c.idx]);
                    K_DATA:  act = fq_data[c.idx];
                    default: act = DW'(fq_stall);
                endcase
                checks++;
                if (act !== c.exp) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%0h want=%0h", c.name, cyc, act, c.exp);
                end
                chk_q.delete(i);
            end else begin
                i++;
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (wb_valid[l]) begin
                checks++;
                if (wb_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected cyc=%0d lane=%0d got addr=%0h data=%0h want none",
                             cyc, l, wb_addr[l], wb_data[l]);
                end else begin
                    w = wb_q.pop_front();
                    if (w.lane != l || w.addr !== wb_addr[l] || w.data !== wb_data[l]) begin
                        errors++;
                        $display("FAIL wb cyc=%0d got lane=%0d addr=%0h data=%0h want lane=%0d addr=%0h data=%0h",
                                 cyc, l, wb_addr[l], wb_data[l], w.lane, w.addr, w.data);
                    end
                end
            end
        end
    end

    initial begin
        rst_n       = 1'b0;
        iss_valid   = '0;
        iss_wr_en   = '0;
        iss_rt_addr = '0;
        iss_lat     = '0;
        iss_data    = '0;
        flush       = 1'b0;
        flush_stage = '0;
        flush_lane  = '0;
        fq_addr     = {FP{7'h7F}};

        // Reset state
        repeat (2) step();
        exp_at(0, "rst_inflight", K_INF, 0, 0);
        exp_at(0, "rst_lat_err", K_LERR, 0, 0);
        exp_at(0, "rst_hit", K_HIT, 0, 0);
        rst_n = 1'b1;
        step();

        // Reset mid-flight discards the entry
        set_iss(0, 1'b1, 7'd5, 4'd2, 128'hA, 1'b0);
        step();
        exp_at(0, "pre_rst_inflight", K_INF, 0, 1);
        repeat (2) step();
        rst_n = 1'b0;
        exp_at(0, "midrst_inflight", K_INF, 0, 0);
        step();
        rst_n = 1'b1;
        exp_at(1, "post_rst_inflight", K_INF, 0, 0);
        drain();

        // Latency tracking on lane 1
        fq_addr[0] = 7'd9;
        set_iss(1, 1'b1, 7'd9, 4'd6, 128'h55, 1'b1);
        step();
        exp_at(0, "lat6_inflight", K_INF, 0, 1);
        for (int a = 1; a <= 5; a++) begin
            exp_at(a - 1, $sformatf("lat6_hit_age%0d", a), K_HIT, 0, 1);
            exp_at(a - 1, $sformatf("lat6_rdy_age%0d", a), K_RDY, 0, 0);
            exp_at(a - 1, $sformatf("lat6_stall_age%0d", a), K_STALL, 0, 1);
        end
        exp_at(5, "lat6_rdy_age6", K_RDY, 0, 1);
        exp_at(5, "lat6_data_age6", K_DATA, 0, 128'h55);
        exp_at(5, "lat6_stall_age6", K_STALL, 0, 0);
        exp_at(8, "lat6_retired_inflight", K_INF, 0, 0);
        drain();

        // Youngest match wins; same-cycle issue not yet visible
        fq_addr[0] = 7'd3;
        set_iss(0, 1'b1, 7'd3, 4'd1, 128'd1, 1'b1);
        exp_at(0, "same_cycle_hidden", K_HIT, 0, 0);
        step();
        set_iss(0, 1'b1, 7'd3, 4'd1, 128'd2, 1'b1);
        step();
        set_iss(0, 1'b1, 7'd4, 4'd1, 128'd7, 1'b0);
        set_iss(1, 1'b1, 7'd4, 4'd1, 128'd8, 1'b1);
        step();
        fq_addr[1] = 7'd4;
        exp_at(0, "young_q3_hit", K_HIT, 0, 1);
        exp_at(0, "young_q3_data", K_DATA, 0, 128'd2);
        exp_at(0, "young_q3_rdy", K_RDY, 0, 1);
        exp_at(0, "young_q4_data", K_DATA, 1, 128'd8);
        exp_at(0, "young_stall", K_STALL, 0, 0);
        drain();

        // Full pipe, then flush at stage 3 lane 0
        for (int i = 0; i < DEPTH; i++) begin
            for (int l = 0; l < LANES; l++) begin
                set_iss(l, 1'b1, AW'(16 + 2*i + l), 4'd1, DW'(256 + 2*i + l),
                        (i <= 3) || (i == 4 && l == 0));
            end
            step();
        end
        exp_at(0, "full_inflight", K_INF, 0, 16);
        flush       = 1'b1;
        flush_stage = 3'd3;
        flush_lane  = 1'd0;
        step();
        exp_at(0, "flush_inflight", K_INF, 0, 7);
        drain();
        exp_at(0, "flush_drained", K_INF, 0, 0);

        // Flush and issue in the same cycle
        set_iss(0, 1'b1, 7'd40, 4'd1, 128'h40, 1'b1);
        step();
        set_iss(0, 1'b1, 7'd41, 4'd1, 128'h41, 1'b0);
        set_iss(1, 1'b1, 7'd42, 4'd1, 128'h42, 1'b0);
        flush       = 1'b1;
        flush_stage = 3'd0;
        flush_lane  = 1'd1;
        fq_addr[0]  = 7'd41;
        fq_addr[1]  = 7'd40;
        step();
        exp_at(0, "fi_inflight", K_INF, 0, 1);
        exp_at(0, "fi_killed_hit", K_HIT, 0, 0);
        exp_at(1, "fi_killed_hit_later", K_HIT, 0, 0);
        exp_at(0, "fi_branch_hit", K_HIT, 1, 1);
        drain();

        // Latency bounds: 0 -> 1, 12 -> clamped to DEPTH with sticky error
        fq_addr[0] = 7'd50;
        fq_addr[1] = 7'd51;
        set_iss(0, 1'b1, 7'd50, 4'd0, 128'h50, 1'b1);
        set_iss(1, 1'b1, 7'd51, 4'd12, 128'h51, 1'b1);
        exp_at(0, "lat_err_clear", K_LERR, 0, 0);
        step();
        exp_at(0, "lat0_rdy_age1", K_RDY, 0, 1);
        exp_at(0, "lat12_rdy_age1", K_RDY, 1, 0);
        exp_at(0, "lat_err_set", K_LERR, 0, 1);
        exp_at(6, "lat12_rdy_age7", K_RDY, 1, 0);
        exp_at(7, "lat12_rdy_age8", K_RDY, 1, 1);
        exp_at(7, "lat12_data_age8", K_DATA, 1, 128'h51);
        drain();
        exp_at(0, "lat_err_sticky", K_LERR, 0, 1);
        repeat (2) step();
        @(negedge clk);
        #1;

        if (chk_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL unchecked_expectations got=%0d want=0", chk_q.size());
        end
        if (wb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL missing_writebacks got=%0d want=0", wb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
